// File: rtl/jtframe_trig_pkg.sv
// jtframe_trig_pkg: shared state encoding and widths for the frame/dump trigger.
package jtframe_trig_pkg;
    localparam int FRAME_W = 32;
    localparam int GUARD_W = 16;
    typedef enum logic [1:0] {WAIT_DL, COUNT, ACTIVE, DONE} state_t;
endpackage

// File: rtl/jtframe_frame_trig_if.sv
// jtframe_frame_trig_if: video/download inputs and frame/dump outputs of the trigger.
interface jtframe_frame_trig_if;
    import jtframe_trig_pkg::*;
    logic               vs;
    logic               downloading;
    logic [FRAME_W-1:0] frame_cnt;
    logic               frame_pulse;
    logic               dump_start;
    logic               dump_en;
    logic               dump_stop;
    modport master (output vs, downloading,
                    input  frame_cnt, frame_pulse, dump_start, dump_en, dump_stop);
    modport slave  (input  vs, downloading,
                    output frame_cnt, frame_pulse, dump_start, dump_en, dump_stop);
endinterface

// File: rtl/jtframe_trig_edge.sv
// jtframe_trig_edge: registered edge detector; RISE selects rising, otherwise falling.
module jtframe_trig_edge #(
    parameter bit RISE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic det
);
    logic q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= din;
    end
    assign det = RISE ? din & ~q : q & ~din;
endmodule

// File: rtl/jtframe_frame_trig.sv
// jtframe_frame_trig: counts vs falls and opens a dump window over a programmed frame range.
// JTFRAME_TRIG_LOADROM_EN holds counting in WAIT_DL until the ROM download completes.
module jtframe_frame_trig
    import jtframe_trig_pkg::*;
#(
    parameter logic [FRAME_W-1:0] START_FRAME = '0,
    parameter logic [FRAME_W-1:0] LENGTH      = '0,
    parameter logic [GUARD_W-1:0] DL_GUARD    = '0
) (
    input logic                 clk,
    input logic                 rst,
    jtframe_frame_trig_if.slave bus
);
    state_t             st_q, st_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d, win_q, win_d;
    logic               pulse_q, pulse_d, start_q, start_d, en_q, en_d, stop_q, stop_d;
    logic               vs_fall;

    jtframe_trig_edge u_vs (.clk(clk), .rst(rst), .din(bus.vs), .det(vs_fall));

`ifdef JTFRAME_TRIG_LOADROM_EN
    localparam state_t RST_ST = WAIT_DL;
    logic               dl_fall;
    logic [GUARD_W-1:0] guard_q;

    jtframe_trig_edge u_dl (.clk(clk), .rst(rst), .din(bus.downloading), .det(dl_fall));

    // Early download edges (power-up glitches) are ignored until the guard saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        guard_q <= '0;
        else if (guard_q != DL_GUARD)   guard_q <= guard_q + 1'b1;
    end
`else
    localparam state_t RST_ST = COUNT;
`endif

    always_comb begin
        st_d        = st_q;
        frame_cnt_d = frame_cnt_q;
        win_d       = win_q;
        en_d        = en_q;
        pulse_d     = 1'b0;
        start_d     = 1'b0;
        stop_d      = 1'b0;
`ifdef JTFRAME_TRIG_LOADROM_EN
        if (st_q == WAIT_DL) begin
            st_d = dl_fall && guard_q == DL_GUARD ? COUNT : WAIT_DL;
        end else if (bus.downloading) begin
            st_d        = WAIT_DL;
            frame_cnt_d = '0;
            en_d        = 1'b0;
            stop_d      = st_q == ACTIVE;
        end else
`endif
        if (vs_fall && st_q != WAIT_DL) begin
            pulse_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (st_q == COUNT && frame_cnt_q == START_FRAME) begin
                st_d    = ACTIVE;
                start_d = 1'b1;
                en_d    = 1'b1;
                win_d   = '0;
            end else if (st_q == ACTIVE) begin
                win_d = win_q + 1'b1;
                // LENGTH of zero keeps the window open indefinitely
                if (LENGTH != '0 && win_d == LENGTH) begin
                    st_d   = DONE;
                    stop_d = 1'b1;
                    en_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= RST_ST;
            frame_cnt_q <= '0;
            win_q       <= '0;
            pulse_q     <= 1'b0;
            start_q     <= 1'b0;
            en_q        <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            frame_cnt_q <= frame_cnt_d;
            win_q       <= win_d;
            pulse_q     <= pulse_d;
            start_q     <= start_d;
            en_q        <= en_d;
            stop_q      <= stop_d;
        end
    end

    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.frame_pulse = pulse_q;
    assign bus.dump_start  = start_q;
    assign bus.dump_en     = en_q;
    assign bus.dump_stop   = stop_q;
endmodule
